// File: rtl/bsg_ral_link_traffic_node_if.sv
// Ready/and link bundle: forward valid/data plus the ready_and_rev
// of the opposite direction; one instance is driven by one node.
`timescale 1ns/1ps
interface bsg_ral_link_traffic_node_if #(
    parameter int flit_width_p = 32
);
    logic                    v;
    logic                    ready_and_rev;
    logic [flit_width_p-1:0] data;

    modport master (output v, output ready_and_rev, output data);
    modport slave  (input  v, input  ready_and_rev, input  data);
endinterface

// File: rtl/bsg_ral_link_traffic_node.sv
// Link traffic node: loopback or pattern generate/check on a ready/and link,
// with send limit, outstanding window, error capture and done flag.
`timescale 1ns/1ps
module bsg_ral_link_traffic_node #(
    parameter int flit_width_p    = 32,
    parameter int channel_width_p = 8,
    parameter int window_width_p  = 8,
    parameter int lb_fifo_els_p   = 2
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      en_i,
    input  logic [1:0]                mode_i,
    input  logic [31:0]               send_limit_i,
    input  logic [window_width_p-1:0] window_i,
    input  logic                      clear_i,
    bsg_ral_link_traffic_node_if.slave  links_sif_i,
    bsg_ral_link_traffic_node_if.master links_sif_o,
    output logic [31:0]               sent_o,
    output logic [31:0]               received_o,
    output logic [window_width_p-1:0] outstanding_o,
    output logic                      error_o,
    output logic [15:0]               error_count_o,
    output logic [flit_width_p-1:0]   first_err_data_o,
    output logic                      done_o
);

    localparam int lanes_lp = flit_width_p / channel_width_p;
    localparam int ptr_w_lp = (lb_fifo_els_p > 1) ? $clog2(lb_fifo_els_p) : 1;
    localparam int cnt_w_lp = $clog2(lb_fifo_els_p + 1);

    typedef enum logic [1:0] {
        MODE_IDLE    = 2'd0,
        MODE_LOOP    = 2'd1,
        MODE_GEN_CHK = 2'd2,
        MODE_GEN     = 2'd3
    } mode_e;

    function automatic logic [flit_width_p-1:0] pattern(
        input logic [channel_width_p-1:0] base
    );
        logic [flit_width_p-1:0] p;
        p = '0;
        for (int c = 0; c < lanes_lp; c++) begin
            p[c*channel_width_p +: channel_width_p] = base + channel_width_p'(c);
        end
        return p;
    endfunction

    function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(lb_fifo_els_p - 1)) ? '0 : p + 1'b1;
    endfunction

    logic [1:0]                rst_sync_q, rst_sync_d;
    logic                      rst_n;

    mode_e                     cfg_mode_q, cfg_mode_d;
    logic [31:0]               cfg_limit_q, cfg_limit_d;
    logic [window_width_p-1:0] cfg_window_q, cfg_window_d;
    logic [31:0]               sent_q, sent_d;
    logic [31:0]               recv_q, recv_d;
    logic                      err_q, err_d;
    logic [15:0]               err_cnt_q, err_cnt_d;
    logic [flit_width_p-1:0]   first_err_q, first_err_d;
    logic                      done_q, done_d;
    logic                      pend_q, pend_d;
    logic [flit_width_p-1:0]   lb_mem_q [lb_fifo_els_p];
    logic [flit_width_p-1:0]   lb_mem_d [lb_fifo_els_p];
    logic [ptr_w_lp-1:0]       lb_wptr_q, lb_wptr_d;
    logic [ptr_w_lp-1:0]       lb_rptr_q, lb_rptr_d;
    logic [cnt_w_lp-1:0]       lb_cnt_q, lb_cnt_d;

    logic                      gen, loop, chk_en;
    logic                      lb_empty, lb_full, can_send;
    logic                      tx_v, rx_ready, send_fire, recv_fire;
    logic                      enq, deq, mismatch;
    logic [flit_width_p-1:0]   tx_data;
    logic [window_width_p-1:0] outstanding;

    assign rst_sync_d = {rst_sync_q[0], 1'b1};
    assign rst_n      = rst_sync_q[1];

    // Reset asserts at once; release waits two clocks.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) rst_sync_q <= 2'b00;
        else            rst_sync_q <= rst_sync_d;
    end

    // Link handshake, loopback buffer, counters, checking and config latch.
    always_comb begin
        gen         = (cfg_mode_q == MODE_GEN_CHK) || (cfg_mode_q == MODE_GEN);
        loop        = (cfg_mode_q == MODE_LOOP);
        chk_en      = (cfg_mode_q == MODE_GEN_CHK);
        outstanding = window_width_p'(sent_q - recv_q);
        lb_empty    = (lb_cnt_q == '0);
        lb_full     = (lb_cnt_q == cnt_w_lp'(lb_fifo_els_p));
        can_send    = en_i
                    && (cfg_limit_q == '0 || sent_q < cfg_limit_q)
                    && (cfg_window_q == '0 || outstanding < cfg_window_q);

        tx_v     = 1'b0;
        tx_data  = '0;
        rx_ready = 1'b0;
        if (gen) begin
            tx_v     = pend_q | can_send;
            rx_ready = 1'b1;
            if (tx_v) tx_data = pattern(sent_q[channel_width_p-1:0]);
        end else if (loop) begin
            tx_v     = ~lb_empty;
            rx_ready = en_i & ~lb_full;
            if (tx_v) tx_data = lb_mem_q[lb_rptr_q];
        end

        send_fire = tx_v & links_sif_i.ready_and_rev;
        recv_fire = links_sif_i.v & rx_ready;
        enq       = loop & recv_fire;
        deq       = loop & send_fire;
        mismatch  = recv_fire && chk_en
                 && (links_sif_i.data != pattern(recv_q[channel_width_p-1:0]));

        cfg_mode_d   = cfg_mode_q;
        cfg_limit_d  = cfg_limit_q;
        cfg_window_d = cfg_window_q;
        if (!en_i) begin
            cfg_mode_d   = mode_e'(mode_i);
            cfg_limit_d  = send_limit_i;
            cfg_window_d = window_i;
        end

        sent_d      = send_fire ? sent_q + 32'd1 : sent_q;
        recv_d      = recv_fire ? recv_q + 32'd1 : recv_q;
        pend_d      = gen & tx_v & ~send_fire;
        err_d       = err_q;
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        if (mismatch) begin
            err_d = 1'b1;
            if (err_cnt_q == 16'd0)     first_err_d = links_sif_i.data;
            if (err_cnt_q != 16'hFFFF)  err_cnt_d   = err_cnt_q + 16'd1;
        end
        done_d = done_q
               | (gen && cfg_limit_q != '0
                  && sent_q == cfg_limit_q && recv_q == cfg_limit_q);

        lb_mem_d  = lb_mem_q;
        lb_wptr_d = lb_wptr_q;
        lb_rptr_d = lb_rptr_q;
        lb_cnt_d  = lb_cnt_q;
        if (enq) begin
            lb_mem_d[lb_wptr_q] = links_sif_i.data;
            lb_wptr_d           = ptr_inc(lb_wptr_q);
        end
        if (deq) lb_rptr_d = ptr_inc(lb_rptr_q);
        case ({enq, deq})
            2'b10:   lb_cnt_d = lb_cnt_q + 1'b1;
            2'b01:   lb_cnt_d = lb_cnt_q - 1'b1;
            default: lb_cnt_d = lb_cnt_q;
        endcase

        if (clear_i) begin
            sent_d      = '0;
            recv_d      = '0;
            err_d       = 1'b0;
            err_cnt_d   = '0;
            first_err_d = '0;
            done_d      = 1'b0;
            pend_d      = 1'b0;
            lb_wptr_d   = '0;
            lb_rptr_d   = '0;
            lb_cnt_d    = '0;
        end
    end

    // State registers, all cleared by the synchronised reset.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            cfg_mode_q   <= MODE_IDLE;
            cfg_limit_q  <= '0;
            cfg_window_q <= '0;
            sent_q       <= '0;
            recv_q       <= '0;
            err_q        <= 1'b0;
            err_cnt_q    <= '0;
            first_err_q  <= '0;
            done_q       <= 1'b0;
            pend_q       <= 1'b0;
            lb_mem_q     <= '{default: '0};
            lb_wptr_q    <= '0;
            lb_rptr_q    <= '0;
            lb_cnt_q     <= '0;
        end else begin
            cfg_mode_q   <= cfg_mode_d;
            cfg_limit_q  <= cfg_limit_d;
            cfg_window_q <= cfg_window_d;
            sent_q       <= sent_d;
            recv_q       <= recv_d;
            err_q        <= err_d;
            err_cnt_q    <= err_cnt_d;
            first_err_q  <= first_err_d;
            done_q       <= done_d;
            pend_q       <= pend_d;
            lb_mem_q     <= lb_mem_d;
            lb_wptr_q    <= lb_wptr_d;
            lb_rptr_q    <= lb_rptr_d;
            lb_cnt_q     <= lb_cnt_d;
        end
    end

    assign links_sif_o.v             = tx_v;
    assign links_sif_o.data          = tx_data;
    assign links_sif_o.ready_and_rev = rx_ready;

    assign sent_o           = sent_q;
    assign received_o       = recv_q;
    assign outstanding_o    = outstanding;
    assign error_o          = err_q;
    assign error_count_o    = err_cnt_q;
    assign first_err_data_o = first_err_q;
    assign done_o           = done_q;

endmodule

// File: tb/tb_bsg_ral_link_traffic_node.sv
// Bench: two nodes back-to-back or node A against a bench-driven peer,
// with a flit-level reference model of node A.
`timescale 1ns/1ps
module tb_bsg_ral_link_traffic_node;

    localparam int FW = 32;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    logic        a_en, b_en, a_clear, b_clear;
    logic [1:0]  a_mode, b_mode;
    logic [31:0] a_limit, b_limit;
    logic [7:0]  a_win, b_win;

    logic [31:0] a_sent, a_recv, b_sent, b_recv;
    logic [7:0]  a_outst, b_outst;
    logic        a_err, b_err, a_done, b_done;
    logic [15:0] a_err_cnt, b_err_cnt;
    logic [31:0] a_first, b_first;

    logic        peer_tb, corrupt_one, corrupt_all;
    logic        tb_v, tb_rdy;
    logic [31:0] tb_data;
    logic        win_chk;

    int checks = 0;
    int failures = 0;

    bsg_ral_link_traffic_node_if #(.flit_width_p(FW)) a_o ();
    bsg_ral_link_traffic_node_if #(.flit_width_p(FW)) a_i ();
    bsg_ral_link_traffic_node_if #(.flit_width_p(FW)) b_o ();
    bsg_ral_link_traffic_node_if #(.flit_width_p(FW)) b_i ();

    bsg_ral_link_traffic_node #(.flit_width_p(FW)) u_a (
        .clk_i(clk), .reset_n_i(reset_n), .en_i(a_en), .mode_i(a_mode),
        .send_limit_i(a_limit), .window_i(a_win), .clear_i(a_clear),
        .links_sif_i(a_i), .links_sif_o(a_o),
        .sent_o(a_sent), .received_o(a_recv), .outstanding_o(a_outst),
        .error_o(a_err), .error_count_o(a_err_cnt),
        .first_err_data_o(a_first), .done_o(a_done)
    );

    bsg_ral_link_traffic_node #(.flit_width_p(FW)) u_b (
        .clk_i(clk), .reset_n_i(reset_n), .en_i(b_en), .mode_i(b_mode),
        .send_limit_i(b_limit), .window_i(b_win), .clear_i(b_clear),
        .links_sif_i(b_i), .links_sif_o(b_o),
        .sent_o(b_sent), .received_o(b_recv), .outstanding_o(b_outst),
        .error_o(b_err), .error_count_o(b_err_cnt),
        .first_err_data_o(b_first), .done_o(b_done)
    );

    function automatic logic [31:0] pat(input logic [7:0] b);
        return {b + 8'd3, b + 8'd2, b + 8'd1, b};
    endfunction

    // Wire between nodes (optionally corrupting B->A) or bench peer on A.
    always_comb begin
        logic [31:0] mask;
        mask = '0;
        if (corrupt_all) mask = 32'h1;
        else if (corrupt_one && b_o.data == 32'h08070605) mask = 32'h8;
        if (peer_tb) begin
            a_i.v = tb_v;
            a_i.data = tb_data;
            a_i.ready_and_rev = tb_rdy;
            b_i.v = 1'b0;
            b_i.data = '0;
            b_i.ready_and_rev = 1'b0;
        end else begin
            a_i.v = b_o.v;
            a_i.data = b_o.data ^ mask;
            a_i.ready_and_rev = b_o.ready_and_rev;
            b_i.v = a_o.v;
            b_i.data = a_o.data;
            b_i.ready_and_rev = a_o.ready_and_rev;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model of node A, compared every cycle.
    logic [31:0] m_sent, m_recv, m_first, m_limit, prev_data;
    logic [1:0]  m_mode;
    logic        m_err, m_done, prev_stall;
    int          m_cnt;

    always @(negedge clk) begin
        logic tx, rx;
        if (!reset_n) begin
            m_sent = 0; m_recv = 0; m_first = 0; m_limit = 0;
            m_mode = 0; m_err = 0; m_done = 0; m_cnt = 0;
            prev_stall = 0; prev_data = 0;
        end else begin
            chk("sent", a_sent, m_sent);
            chk("received", a_recv, m_recv);
            chk("err_count", a_err_cnt, 64'(m_cnt));
            chk("error", a_err, m_err);
            chk("first_err", a_first, m_first);
            chk("done", a_done, m_done);
            if (prev_stall) begin
                chk("v_hold", a_o.v, 1);
                chk("data_hold", a_o.data, prev_data);
            end
            if (win_chk) chk("window", a_outst <= 8'd4, 1);
            tx = a_o.v & a_i.ready_and_rev;
            rx = a_i.v & a_o.ready_and_rev;
            if (tx && m_mode[1]) chk("tx_data", a_o.data, pat(m_sent[7:0]));
            if (a_clear) begin
                m_sent = 0; m_recv = 0; m_first = 0;
                m_err = 0; m_done = 0; m_cnt = 0; prev_stall = 0;
            end else begin
                if (m_mode[1] && m_limit != 0 && m_sent == m_limit
                    && m_recv == m_limit) m_done = 1;
                if (rx && m_mode == 2'd2 && a_i.data !== pat(m_recv[7:0])) begin
                    if (m_cnt == 0) m_first = a_i.data;
                    m_err = 1;
                    if (m_cnt < 65535) m_cnt++;
                end
                if (rx) m_recv++;
                if (tx) m_sent++;
                prev_stall = a_o.v && !a_i.ready_and_rev;
                prev_data = a_o.data;
            end
            if (!a_en) begin
                m_mode = a_mode;
                m_limit = a_limit;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic quiesce();
        a_en = 0; b_en = 0; tb_rdy = 1; tb_v = 0;
        step(2);
        a_clear = 1; b_clear = 1;
        step(1);
        a_clear = 0; b_clear = 0;
    endtask

    initial begin
        int first, last, k;
        a_en = 0; b_en = 0; a_clear = 0; b_clear = 0;
        a_mode = 0; b_mode = 0; a_limit = 0; b_limit = 0;
        a_win = 0; b_win = 0;
        peer_tb = 0; corrupt_one = 0; corrupt_all = 0;
        tb_v = 0; tb_rdy = 0; tb_data = 0; win_chk = 0;

        #2 reset_n = 0;
        step(3);
        chk("rst_sent", a_sent, 0);
        chk("rst_recv", a_recv, 0);
        chk("rst_v", a_o.v, 0);
        chk("rst_rdy", a_o.ready_and_rev, 0);
        chk("rst_done", a_done, 0);
        chk("rst_b_v", b_o.v, 0);
        reset_n = 1;
        step(4);

        // Both nodes generate and check 100 flits.
        a_mode = 2; b_mode = 2; a_limit = 100; b_limit = 100;
        step(1);
        a_en = 1; b_en = 1;
        first = -1; last = -1;
        for (int i = 0; i < 400 && !(a_done && b_done); i++) begin
            step(1);
            if (first < 0 && a_sent != 0) first = i;
            if (last < 0 && a_sent == 100) last = i;
        end
        chk("t1_done", a_done & b_done, 1);
        chk("t1_rate", 64'(last - first), 99);
        chk("t1_b_sent", b_sent, 100);
        chk("t1_b_recv", b_recv, 100);
        chk("t1_b_errs", b_err_cnt, 0);
        chk("t1_a_errs", a_err_cnt, 0);
        quiesce();

        // A generates through B loopback with a window of 4.
        a_mode = 2; a_limit = 1000; a_win = 4;
        b_mode = 1; b_limit = 1000; b_win = 0;
        step(1);
        win_chk = 1; a_en = 1; b_en = 1;
        for (int i = 0; i < 3000 && !a_done; i++) step(1);
        win_chk = 0;
        chk("t2_done", a_done, 1);
        chk("t2_recv", a_recv, 1000);
        chk("t2_b_sent", b_sent, 1000);
        chk("t2_b_done", b_done, 0);
        quiesce();

        // One bit flipped on flit seq 5.
        corrupt_one = 1; a_limit = 20; a_win = 0;
        step(1);
        a_en = 1; b_en = 1;
        for (int i = 0; i < 200 && !a_done; i++) step(1);
        chk("t3_done", a_done, 1);
        chk("t3_error", a_err, 1);
        chk("t3_count", a_err_cnt, 1);
        chk("t3_first", a_first, 32'h0807060D);
        corrupt_one = 0;
        quiesce();

        // Bench peer: random backpressure and random rx with errors.
        peer_tb = 1; a_mode = 2; a_limit = 0; a_win = 0;
        step(1);
        a_en = 1; k = 0;
        for (int i = 0; i < 400; i++) begin
            tb_rdy = ($urandom_range(0, 9) < 7);
            tb_v = 1'($urandom_range(0, 1));
            tb_data = pat(k[7:0]);
            if ($urandom_range(0, 7) == 0)
                tb_data = tb_data ^ (32'h1 << $urandom_range(0, 31));
            step(1);
            if (tb_v) k++;
        end
        tb_v = 0;
        chk("t4_recv", a_recv, 64'(k));
        chk("t4_errs_seen", a_err_cnt != 0, 1);
        quiesce();
        a_mode = 3;
        step(1);
        a_en = 1; k = 0;
        for (int i = 0; i < 100; i++) begin
            tb_rdy = ($urandom_range(0, 9) < 7);
            tb_v = 1'($urandom_range(0, 1));
            tb_data = $urandom;
            step(1);
            if (tb_v) k++;
        end
        tb_v = 0;
        chk("t4_sink_recv", a_recv, 64'(k));
        chk("t4_sink_err", a_err, 0);
        quiesce();

        // Clear with a fire, ignored mode change, async reset pulse.
        a_mode = 2;
        step(1);
        a_en = 1; tb_rdy = 1;
        step(5);
        a_clear = 1;
        step(1);
        a_clear = 0;
        chk("t6_clr_sent", a_sent, 0);
        chk("t6_clr_recv", a_recv, 0);
        a_mode = 0;
        step(10);
        chk("t6_mode_ign_sent", a_sent, 10);
        chk("t6_mode_ign_v", a_o.v, 1);
        #3 reset_n = 0;
        #1;
        chk("t6_rst_sent", a_sent, 0);
        chk("t6_rst_v", a_o.v, 0);
        chk("t6_rst_rdy", a_o.ready_and_rev, 0);
        chk("t6_rst_data", a_o.data, 0);
        chk("t6_rst_outst", a_outst, 0);
        a_mode = 2;
        #3 reset_n = 1;
        step(4);
        chk("t6_cfg_idle_v", a_o.v, 0);
        chk("t6_cfg_idle_rdy", a_o.ready_and_rev, 0);
        a_en = 0;
        step(1);
        a_en = 1;
        step(10);
        chk("t6_restart_sent", a_sent, 10);
        quiesce();
        peer_tb = 0;

        // Every flit corrupted: error count saturates.
        corrupt_all = 1;
        a_mode = 2; a_limit = 65540; a_win = 0; b_mode = 1; b_limit = 0;
        step(1);
        a_en = 1; b_en = 1;
        for (int i = 0; i < 66000 && !a_done; i++) step(1);
        chk("t5_done", a_done, 1);
        chk("t5_recv", a_recv, 65540);
        chk("t5_sat", a_err_cnt, 16'hFFFF);
        chk("t5_first", a_first, 32'h03020101);
        corrupt_all = 0;
        quiesce();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
